// File: rtl/cu_res_alloc_ctrl_pkg.sv
// Shared constants and FSM encoding for the CU resource allocator.
// NUMBER_CU / CU_ID_WIDTH normally arrive from define.v; these guarded values only fill in when absent.
`ifndef NUMBER_CU
`define NUMBER_CU 4
`endif
`ifndef CU_ID_WIDTH
`define CU_ID_WIDTH 2
`endif

package cu_res_alloc_ctrl_pkg;

  localparam int unsigned ResIdWidthDefault = 10;

  function automatic int unsigned res_max(input int unsigned width);
    return 32'd1 << width;
  endfunction

  localparam int unsigned RES_MAX = res_max(ResIdWidthDefault);

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StEval,
    StUpdate,
    StDealloc
  } alloc_state_e;

endpackage

// File: rtl/cu_rr_picker.sv
// Round-robin first-one finder: first set bit at or after ptr, wrapping modulo NumCu.
module cu_rr_picker #(
  parameter int unsigned NumCu    = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumCu-1:0]    vector,
  input  logic [IdxWidth-1:0] ptr,
  output logic                found,
  output logic [IdxWidth-1:0] index
);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int unsigned i = 0; i < NumCu; i++) begin
      j = 32'(ptr) + i;
      if (j >= NumCu) j = j - NumCu;
      if (!found && vector[j]) begin
        found = 1'b1;
        index = IdxWidth'(j);
      end
    end
  end

endmodule

// File: rtl/cu_res_alloc_ctrl.sv
// Per-CU free-count allocator: searches a fit CAM, grants round-robin, and mirrors table writes
// back into the CAM. Deallocations saturate at RES_MAX.
`ifndef NUMBER_CU
`define NUMBER_CU 4
`endif
`ifndef CU_ID_WIDTH
`define CU_ID_WIDTH 2
`endif

module cu_res_alloc_ctrl
  import cu_res_alloc_ctrl_pkg::*;
#(
  parameter int unsigned RES_ID_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid_i,
  input  logic [RES_ID_WIDTH:0]     alloc_size_i,
  output logic                      alloc_ready_o,
  output logic                      alloc_done_o,
  output logic                      alloc_fail_o,
  output logic [`CU_ID_WIDTH-1:0]   alloc_cu_id_o,
  input  logic                      dealloc_valid_i,
  output logic                      dealloc_ready_o,
  input  logic [`CU_ID_WIDTH-1:0]   dealloc_cu_id_i,
  input  logic [RES_ID_WIDTH:0]     dealloc_size_i,
  output logic                      cam_wr_en_o,
  output logic [`CU_ID_WIDTH-1:0]   cam_wr_addr_o,
  output logic [RES_ID_WIDTH:0]     cam_wr_data_o,
  output logic                      res_search_en_o,
  output logic [RES_ID_WIDTH:0]     res_search_size_o,
  input  logic [`NUMBER_CU-1:0]     res_search_out_i
);

  localparam int unsigned NumCu = `NUMBER_CU;
  localparam int unsigned CuIdW = `CU_ID_WIDTH;
  localparam logic [RES_ID_WIDTH:0] ResMax = (RES_ID_WIDTH + 1)'(res_max(RES_ID_WIDTH));

  alloc_state_e            state_q;
  logic [CuIdW-1:0]        rr_ptr_q;
  logic [CuIdW-1:0]        pick_q;
  logic [RES_ID_WIDTH:0]   size_q;
  logic [CuIdW-1:0]        dl_cu_q;
  logic [RES_ID_WIDTH:0]   dl_size_q;
  logic [RES_ID_WIDTH:0]   free_q [NumCu];

  logic                    pick_found;
  logic [CuIdW-1:0]        pick_idx;
  logic [RES_ID_WIDTH:0]   alloc_left;
  logic [RES_ID_WIDTH+1:0] dl_sum;
  logic [RES_ID_WIDTH:0]   dl_new;

  assign alloc_ready_o   = (state_q == StIdle) && !dealloc_valid_i;
  assign dealloc_ready_o = (state_q == StIdle);

  cu_rr_picker #(
    .NumCu   (NumCu),
    .IdxWidth(CuIdW)
  ) u_picker (
    .vector(res_search_out_i),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  // The CAM only reports fits, so the subtraction cannot underflow.
  always_comb begin
    alloc_left = free_q[pick_q] - size_q;
    dl_sum     = {1'b0, free_q[dl_cu_q]} + {1'b0, dl_size_q};
    dl_new     = (dl_sum > {1'b0, ResMax}) ? ResMax : dl_sum[RES_ID_WIDTH:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      rr_ptr_q          <= '0;
      pick_q            <= '0;
      size_q            <= '0;
      dl_cu_q           <= '0;
      dl_size_q         <= '0;
      for (int i = 0; i < NumCu; i++) free_q[i] <= ResMax;
      alloc_done_o      <= 1'b0;
      alloc_fail_o      <= 1'b0;
      alloc_cu_id_o     <= '0;
      cam_wr_en_o       <= 1'b0;
      cam_wr_addr_o     <= '0;
      cam_wr_data_o     <= '0;
      res_search_en_o   <= 1'b0;
      res_search_size_o <= '0;
    end else begin
      alloc_done_o    <= 1'b0;
      alloc_fail_o    <= 1'b0;
      cam_wr_en_o     <= 1'b0;
      res_search_en_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dealloc_valid_i) begin
            dl_cu_q   <= dealloc_cu_id_i;
            dl_size_q <= dealloc_size_i;
            state_q   <= StDealloc;
          end else if (alloc_valid_i) begin
            size_q            <= alloc_size_i;
            res_search_en_o   <= 1'b1;
            res_search_size_o <= alloc_size_i;
            state_q           <= StSearch;
          end
        end
        StSearch: state_q <= StEval;
        StEval: begin
          if (pick_found) begin
            pick_q  <= pick_idx;
            state_q <= StUpdate;
          end else begin
            alloc_fail_o <= 1'b1;
            state_q      <= StIdle;
          end
        end
        StUpdate: begin
          free_q[pick_q] <= alloc_left;
          cam_wr_en_o    <= 1'b1;
          cam_wr_addr_o  <= pick_q;
          cam_wr_data_o  <= alloc_left;
          alloc_done_o   <= 1'b1;
          alloc_cu_id_o  <= pick_q;
          rr_ptr_q       <= (pick_q == CuIdW'(NumCu - 1)) ? '0 : pick_q + 1'b1;
          state_q        <= StIdle;
        end
        StDealloc: begin
          free_q[dl_cu_q] <= dl_new;
          cam_wr_en_o     <= 1'b1;
          cam_wr_addr_o   <= dl_cu_q;
          cam_wr_data_o   <= dl_new;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_res_alloc_ctrl.sv
// Randomised scoreboard bench for cu_res_alloc_ctrl with a registered fit-CAM model.
module tb_cu_res_alloc_ctrl;

  localparam int ResMax = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid_i = 1'b0;
  logic [10:0] alloc_size_i = '0;
  logic        alloc_ready_o, alloc_done_o, alloc_fail_o;
  logic [1:0]  alloc_cu_id_o;
  logic        dealloc_valid_i = 1'b0;
  logic        dealloc_ready_o;
  logic [1:0]  dealloc_cu_id_i = '0;
  logic [10:0] dealloc_size_i = '0;
  logic        cam_wr_en_o;
  logic [1:0]  cam_wr_addr_o;
  logic [10:0] cam_wr_data_o;
  logic        res_search_en_o;
  logic [10:0] res_search_size_o;
  logic [3:0]  res_search_out_i;

  cu_res_alloc_ctrl #(.RES_ID_WIDTH(10)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_size_i     (alloc_size_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_done_o     (alloc_done_o),
    .alloc_fail_o     (alloc_fail_o),
    .alloc_cu_id_o    (alloc_cu_id_o),
    .dealloc_valid_i  (dealloc_valid_i),
    .dealloc_ready_o  (dealloc_ready_o),
    .dealloc_cu_id_i  (dealloc_cu_id_i),
    .dealloc_size_i   (dealloc_size_i),
    .cam_wr_en_o      (cam_wr_en_o),
    .cam_wr_addr_o    (cam_wr_addr_o),
    .cam_wr_data_o    (cam_wr_data_o),
    .res_search_en_o  (res_search_en_o),
    .res_search_size_o(res_search_size_o),
    .res_search_out_i (res_search_out_i)
  );

  always #5 clk = ~clk;

  // Fit CAM: one-cycle registered search over the values the DUT has written.
  logic [10:0] cam_mem [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cam_mem[i] <= 11'd1024;
      res_search_out_i <= '0;
    end else begin
      if (cam_wr_en_o) cam_mem[cam_wr_addr_o] <= cam_wr_data_o;
      if (res_search_en_o)
        for (int i = 0; i < 4; i++) res_search_out_i[i] <= (cam_mem[i] >= res_search_size_o);
    end
  end

  // Reference model: kind 0 = grant, 1 = no fit, 2 = dealloc write.
  typedef struct {int kind; int cu; int data;} ev_t;
  ev_t evq[$];
  int  sq[$];
  int  free_m[4];
  int  rr_m;
  int  n_checks = 0;
  int  n_fail = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event, expected none (t=%0t)", name, $time);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) free_m[i] = ResMax;
    rr_m = 0;
  endfunction

  function automatic void model_alloc(input int sz);
    ev_t e;
    int  c;
    e.kind = 1; e.cu = 0; e.data = 0;
    sq.push_back(sz);
    for (int k = 0; k < 4; k++) begin
      c = (rr_m + k) % 4;
      if (e.kind == 1 && free_m[c] >= sz) begin
        e.kind = 0; e.cu = c; e.data = free_m[c] - sz;
      end
    end
    if (e.kind == 0) begin
      free_m[e.cu] = e.data;
      rr_m = (e.cu + 1) % 4;
    end
    evq.push_back(e);
  endfunction

  function automatic void model_dealloc(input int cu, input int sz);
    ev_t e;
    e.kind = 2; e.cu = cu;
    e.data = (free_m[cu] + sz > ResMax) ? ResMax : free_m[cu] + sz;
    free_m[cu] = e.data;
    evq.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (res_search_en_o) begin
        check("search_vs_cam_write", int'(cam_wr_en_o), 0);
        if (sq.size() == 0) flag("search_unexpected");
        else check("search_size", int'(res_search_size_o), sq.pop_front());
      end
      if (alloc_done_o || alloc_fail_o || cam_wr_en_o) begin
        if (evq.size() == 0) flag("event_unexpected");
        else begin
          ev_t e;
          int  k;
          e = evq.pop_front();
          k = alloc_done_o ? 0 : (alloc_fail_o ? 1 : 2);
          check("event_kind", k, e.kind);
          if (e.kind == 0) begin
            check("grant_cu", int'(alloc_cu_id_o), e.cu);
            check("grant_cam_wr_en", int'(cam_wr_en_o), 1);
            check("grant_cam_addr", int'(cam_wr_addr_o), e.cu);
            check("grant_cam_data", int'(cam_wr_data_o), e.data);
          end else if (e.kind == 1) begin
            check("fail_no_cam_wr", int'(cam_wr_en_o), 0);
          end else begin
            check("dealloc_cam_addr", int'(cam_wr_addr_o), e.cu);
            check("dealloc_cam_data", int'(cam_wr_data_o), e.data);
          end
        end
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    check(name, int'({alloc_done_o, alloc_fail_o, alloc_cu_id_o, cam_wr_en_o, cam_wr_addr_o,
                      cam_wr_data_o, res_search_en_o, res_search_size_o}), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_alloc_ready", int'(alloc_ready_o), 1);
    check("reset_dealloc_ready", int'(dealloc_ready_o), 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((evq.size() != 0 || sq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", evq.size() + sq.size(), 0);
  endtask

  task automatic do_alloc(input int sz);
    int n = 0;
    @(negedge clk);
    alloc_valid_i = 1'b1;
    alloc_size_i  = 11'(sz);
    #1;
    while (!alloc_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!alloc_ready_o) flag("alloc_ready_timeout");
    else model_alloc(sz);
    @(posedge clk);
    #1;
    alloc_valid_i = 1'b0;
  endtask

  task automatic do_dealloc(input int cu, input int sz);
    int n = 0;
    @(negedge clk);
    dealloc_valid_i = 1'b1;
    dealloc_cu_id_i = 2'(cu);
    dealloc_size_i  = 11'(sz);
    #1;
    while (!dealloc_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!dealloc_ready_o) flag("dealloc_ready_timeout");
    else model_dealloc(cu, sz);
    @(posedge clk);
    #1;
    dealloc_valid_i = 1'b0;
  endtask

  // Both requests in the same IDLE cycle: dealloc first, alloc two cycles later.
  task automatic do_both(input int cu, input int dsz, input int asz);
    int n = 0;
    @(negedge clk);
    alloc_valid_i   = 1'b1;
    alloc_size_i    = 11'(asz);
    dealloc_valid_i = 1'b1;
    dealloc_cu_id_i = 2'(cu);
    dealloc_size_i  = 11'(dsz);
    #1;
    check("both_alloc_ready", int'(alloc_ready_o), 0);
    check("both_dealloc_ready", int'(dealloc_ready_o), 1);
    model_dealloc(cu, dsz);
    @(posedge clk);
    #1;
    dealloc_valid_i = 1'b0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!alloc_ready_o && n < 20);
    check("both_alloc_delay", n, 2);
    if (alloc_ready_o) model_alloc(asz);
    @(posedge clk);
    #1;
    alloc_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    apply_reset();

    do_alloc(100);
    do_alloc(100);
    do_alloc(1025);
    do_alloc(100);
    drain();

    apply_reset();
    for (int i = 0; i < 4; i++) do_alloc(1024);
    do_alloc(1);
    do_dealloc(2, 500);
    do_alloc(400);
    do_alloc(0);
    drain();

    apply_reset();
    do_both(1, 100, 100);
    drain();

    // Abort mid-EVAL: only the search is expected, never a done/fail.
    @(negedge clk);
    alloc_valid_i = 1'b1;
    alloc_size_i  = 11'd100;
    sq.push_back(100);
    @(posedge clk);
    #1;
    alloc_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("abort_outputs");
    repeat (3) @(negedge clk);
    check_outputs_zero("abort_outputs_held");
    rst_n = 1'b1;
    do_alloc(100);
    drain();

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 3) do_dealloc(int'($urandom_range(0, 3)), int'($urandom_range(0, 700)));
      else if ($urandom_range(0, 3) == 0) do_alloc(int'($urandom_range(1000, 1100)));
      else do_alloc(int'($urandom_range(0, 400)));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
